// File: rtl/uart_rx_frame_check_pkg.sv
// Shared types and parameter legality helpers for the UART RX frame checker.
package uart_chk_pkg;

  typedef enum logic [2:0] {
    IDLE,
    DATA,
    PARITY,
    STOP,
    DONE
  } state_e;

  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  function automatic bit data_width_legal(input int w);
    return (w >= 5) && (w <= 9);
  endfunction

  function automatic bit stop_bits_legal(input int n);
    return (n == 1) || (n == 2);
  endfunction

endpackage

// File: rtl/uart_rx_frame_check_if.sv
// Strobe inputs from the RX FSM/sampler and per-frame status/counter outputs.
interface uart_rx_frame_check_if #(
  parameter int CNT_WIDTH = 8
);
  logic                 sampled_bit;
  logic                 strt_chk_en;
  logic                 data_bit_en;
  logic                 par_chk_en;
  logic                 stp_chk_en;
  logic                 PAR_EN;
  logic                 PAR_TYP;
  logic                 cnt_clr;
  logic                 strt_glitch;
  logic                 par_err;
  logic                 stp_err;
  logic                 seq_err;
  logic                 frame_valid;
  logic                 frame_ok;
  logic [CNT_WIDTH-1:0] glitch_cnt;
  logic [CNT_WIDTH-1:0] par_err_cnt;
  logic [CNT_WIDTH-1:0] stp_err_cnt;

  modport master (
    output sampled_bit, strt_chk_en, data_bit_en, par_chk_en, stp_chk_en,
    output PAR_EN, PAR_TYP, cnt_clr,
    input  strt_glitch, par_err, stp_err, seq_err, frame_valid, frame_ok,
    input  glitch_cnt, par_err_cnt, stp_err_cnt
  );

  modport slave (
    input  sampled_bit, strt_chk_en, data_bit_en, par_chk_en, stp_chk_en,
    input  PAR_EN, PAR_TYP, cnt_clr,
    output strt_glitch, par_err, stp_err, seq_err, frame_valid, frame_ok,
    output glitch_cnt, par_err_cnt, stp_err_cnt
  );
endinterface

// File: rtl/uart_rx_frame_check_sat_counter.sv
// Saturating up-counter; clear beats a coincident increment.
module sat_counter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [WIDTH-1:0] count
);
  logic [WIDTH-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != '1)) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;
endmodule

// File: rtl/uart_rx_frame_check.sv
// Whole-frame UART RX checker: start glitch, parity, stop bits and strobe order,
// with per-frame status and saturating error counters.
module uart_rx_frame_check
  import uart_chk_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int STOP_BITS  = 1,
  parameter int CNT_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  uart_rx_frame_check_if.slave  bus
);
  localparam int BW = $clog2(DATA_WIDTH + 1);

  if (!data_width_legal(DATA_WIDTH)) begin : g_bad_data_width
    $error("uart_rx_frame_check: DATA_WIDTH must be within 5..9");
  end
  if (!stop_bits_legal(STOP_BITS)) begin : g_bad_stop_bits
    $error("uart_rx_frame_check: STOP_BITS must be 1 or 2");
  end

  state_e          r_state;
  logic            r_acc;
  logic [BW-1:0]   r_bit_cnt;
  logic [1:0]      r_stop_cnt;
  logic            r_par_en;
  logic            r_par_typ;
  logic            r_strt_glitch;
  logic            r_par_err;
  logic            r_stp_err;
  logic            r_seq_err;
  logic            r_frame_valid;
  logic            r_frame_ok;

  // The DONE cycle ignores every strobe, including a start.
  logic w_strt;
  logic w_glitch_inc;
  logic w_par_inc;
  logic w_stp_inc;

  assign w_strt       = bus.strt_chk_en && (r_state != DONE);
  assign w_glitch_inc = w_strt && bus.sampled_bit;
  assign w_par_inc    = (r_state == DONE) && r_par_err;
  assign w_stp_inc    = (r_state == DONE) && r_stp_err;

  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state       <= IDLE;
      r_acc         <= 1'b0;
      r_bit_cnt     <= '0;
      r_stop_cnt    <= '0;
      r_par_en      <= 1'b0;
      r_par_typ     <= PAR_EVEN;
      r_strt_glitch <= 1'b0;
      r_par_err     <= 1'b0;
      r_stp_err     <= 1'b0;
      r_seq_err     <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_ok    <= 1'b0;
    end else begin
      r_seq_err     <= 1'b0;
      r_frame_valid <= 1'b0;
      r_frame_ok    <= 1'b0;
      if (w_strt) begin
        // A start mid-frame abandons the partial frame and is re-evaluated as from IDLE.
        r_seq_err     <= (r_state != IDLE);
        r_strt_glitch <= bus.sampled_bit;
        if (bus.sampled_bit) begin
          r_state <= IDLE;
        end else begin
          r_state    <= DATA;
          r_par_en   <= bus.PAR_EN;
          r_par_typ  <= bus.PAR_TYP;
          r_par_err  <= 1'b0;
          r_stp_err  <= 1'b0;
          r_acc      <= 1'b0;
          r_bit_cnt  <= '0;
          r_stop_cnt <= '0;
        end
      end else begin
        case (r_state)
          DATA: begin
            if (bus.data_bit_en) begin
              r_acc     <= r_acc ^ bus.sampled_bit;
              r_bit_cnt <= r_bit_cnt + 1'b1;
              if (r_bit_cnt == BW'(DATA_WIDTH - 1)) begin
                r_state <= r_par_en ? PARITY : STOP;
              end
            end else if (bus.par_chk_en || bus.stp_chk_en) begin
              r_seq_err <= 1'b1;
              r_state   <= IDLE;
            end
          end
          PARITY: begin
            if (bus.data_bit_en) begin
              r_seq_err <= 1'b1;
              r_state   <= IDLE;
            end else if (bus.par_chk_en) begin
              r_par_err <= bus.sampled_bit ^ r_acc ^ (r_par_typ == PAR_ODD);
              r_state   <= STOP;
            end else if (bus.stp_chk_en) begin
              r_seq_err <= 1'b1;
              r_state   <= IDLE;
            end
          end
          STOP: begin
            if (bus.data_bit_en || bus.par_chk_en) begin
              r_seq_err <= 1'b1;
              r_state   <= IDLE;
            end else if (bus.stp_chk_en) begin
              r_stp_err  <= r_stp_err | ~bus.sampled_bit;
              r_stop_cnt <= r_stop_cnt + 1'b1;
              if (r_stop_cnt == 2'(STOP_BITS - 1)) begin
                r_state       <= DONE;
                r_frame_valid <= 1'b1;
                r_frame_ok    <= ~(r_par_err | r_stp_err | ~bus.sampled_bit);
              end
            end
          end
          DONE:    r_state <= IDLE;
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.strt_glitch = r_strt_glitch;
  assign bus.par_err     = r_par_err;
  assign bus.stp_err     = r_stp_err;
  assign bus.seq_err     = r_seq_err;
  assign bus.frame_valid = r_frame_valid;
  assign bus.frame_ok    = r_frame_ok;

  sat_counter #(.WIDTH(CNT_WIDTH)) u_glitch_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (w_glitch_inc),
    .clr   (bus.cnt_clr),
    .count (bus.glitch_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_par_err_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (w_par_inc),
    .clr   (bus.cnt_clr),
    .count (bus.par_err_cnt)
  );

  sat_counter #(.WIDTH(CNT_WIDTH)) u_stp_err_cnt (
    .clk   (CLK),
    .rst   (RST),
    .inc   (w_stp_inc),
    .clr   (bus.cnt_clr),
    .count (bus.stp_err_cnt)
  );
endmodule
